// File: rtl/proc_hier.sv
// proc_hier: single-cycle 16-bit teaching processor core.
// Fetch, decode, register file, ALU, branch unit and cycle counter in one clock domain.
// Instruction and data memories sit outside; all trace outputs are combinational.
module proc_hier (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_en,
  output logic        dmem_wr,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic        reg_wrt,
  output logic [2:0]  write_reg_sel,
  output logic [15:0] write_data,
  output logic        halt,
  output logic [31:0] cycle_count
);

  localparam int unsigned XLEN = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned RSEL = 3;
  localparam int unsigned CW   = 32;

  typedef enum logic [4:0] {
    OP_HALT  = 5'b00000,
    OP_NOP   = 5'b00001,
    OP_J     = 5'b00100,
    OP_ADDI  = 5'b01000,
    OP_SUBI  = 5'b01001,
    OP_BEQZ  = 5'b01100,
    OP_BNEZ  = 5'b01101,
    OP_ST    = 5'b10000,
    OP_LD    = 5'b10001,
    OP_LBI   = 5'b11000,
    OP_RTYPE = 5'b11011
  } opcode_t;

  logic [XLEN-1:0] rf [NREG];
  logic            halted;
  opcode_t         op;
  logic [RSEL-1:0] rs, rt, rd;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [XLEN-1:0] imm5, imm8, disp11;
  logic [XLEN-1:0] pc_inc, next_pc, alu;

  // Field extraction and sign extension of the immediates
  assign instr     = imem_data;
  assign imem_addr = pc;
  assign op        = opcode_t'(instr[15:11]);
  assign rs        = instr[10:8];
  assign rt        = instr[7:5];
  assign rd        = instr[4:2];
  assign rs_val    = rf[rs];
  assign rt_val    = rf[rt];
  assign imm5      = {{(XLEN-5){instr[4]}}, instr[4:0]};
  assign imm8      = {{(XLEN-8){instr[7]}}, instr[7:0]};
  assign disp11    = {{(XLEN-11){instr[10]}}, instr[10:0]};
  assign pc_inc    = pc + XLEN'(2);
  assign dmem_addr  = alu;
  assign dmem_wdata = rt_val;

  // ALU: base+offset by default, overridden for the arithmetic/logic opcodes
  always_comb begin
    alu = rs_val + imm5;
    case (op)
      OP_SUBI: alu = imm5 - rs_val;
      OP_LBI:  alu = imm8;
      OP_RTYPE: begin
        case (instr[1:0])
          2'b00:   alu = rs_val + rt_val;
          2'b01:   alu = rt_val - rs_val;
          2'b10:   alu = rs_val ^ rt_val;
          default: alu = rs_val & ~rt_val;
        endcase
      end
      default: ;
    endcase
  end

  // Control decode, writeback selection and next-pc
  always_comb begin
    reg_wrt       = 1'b0;
    write_reg_sel = rt;
    write_data    = alu;
    dmem_en       = 1'b0;
    dmem_wr       = 1'b0;
    halt          = halted;
    next_pc       = pc_inc;
    case (op)
      OP_HALT: begin
        halt    = 1'b1;
        next_pc = pc;
      end
      OP_ADDI, OP_SUBI: reg_wrt = 1'b1;
      OP_ST: begin
        dmem_en = 1'b1;
        dmem_wr = 1'b1;
      end
      OP_LD: begin
        dmem_en    = 1'b1;
        reg_wrt    = 1'b1;
        write_data = dmem_rdata;
      end
      OP_LBI: begin
        reg_wrt       = 1'b1;
        write_reg_sel = rs;
      end
      OP_RTYPE: begin
        reg_wrt       = 1'b1;
        write_reg_sel = rd;
      end
      OP_BEQZ: if (rs_val == '0) next_pc = pc_inc + imm8;
      OP_BNEZ: if (rs_val != '0) next_pc = pc_inc + imm8;
      OP_J:    next_pc = pc_inc + disp11;
      default: ;
    endcase
    // Once halted nothing may be written even if the fetched word changes
    if (halted) begin
      reg_wrt = 1'b0;
      dmem_en = 1'b0;
      dmem_wr = 1'b0;
    end
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (reg_wrt && !halt) begin
      rf[write_reg_sel] <= write_data;
    end
  end

  // pc, cycle counter and sticky halted flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      cycle_count <= '0;
      halted      <= 1'b0;
    end else if (halt) begin
      halted <= 1'b1;
    end else begin
      pc          <= next_pc;
      cycle_count <= cycle_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_proc_hier.sv
// tb_proc_hier: directed literal checks plus randomized programs against an ISA-level model.
module tb_proc_hier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] pc, instr, write_data;
  logic        dmem_en, dmem_wr, reg_wrt, halt;
  logic [2:0]  write_reg_sel;
  logic [31:0] cycle_count;

  proc_hier dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_en(dmem_en), .dmem_wr(dmem_wr),
    .pc(pc), .instr(instr),
    .reg_wrt(reg_wrt), .write_reg_sel(write_reg_sel), .write_data(write_data),
    .halt(halt), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // External memories (word-per-even-address)
  logic [15:0] imem [32768];
  logic [15:0] dmem [32768];
  assign imem_data  = imem[imem_addr[15:1]];
  assign dmem_rdata = dmem[dmem_addr[15:1]];
  always @(posedge clk) if (rst && dmem_en && dmem_wr) dmem[dmem_addr[15:1]] <= dmem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  logic [15:0] prog [$];
  logic [4:0]  ops [10] = '{5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b11000,
                            5'b11011, 5'b01100, 5'b01101, 5'b00100, 5'b00001};

  // ISA-level model state
  logic [15:0] m_r [8];
  logic [15:0] m_dm [32768];
  logic [15:0] m_pc;
  logic [31:0] m_cyc;
  bit          m_halted;

  // Model predictions for the instruction at m_pc
  bit          e_wr, e_en, e_dwr, e_halt;
  logic [2:0]  e_sel;
  logic [15:0] e_data, e_addr, e_wdata, e_npc, e_instr;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int sx(input logic [15:0] v, input int bits);
    int u;
    u = int'(v) & ((1 << bits) - 1);
    return (u >= (1 << (bits - 1))) ? u - (1 << bits) : u;
  endfunction

  task automatic predict();
    logic [15:0] w, a, b;
    int i5, i8, d11;
    w = imem[m_pc[15:1]];
    e_instr = w;
    a = m_r[w[10:8]];
    b = m_r[w[7:5]];
    i5  = sx(w, 5);
    i8  = sx(w, 8);
    d11 = sx(w, 11);
    e_wr = 0; e_en = 0; e_dwr = 0; e_halt = m_halted; e_sel = 3'd0; e_data = 16'd0;
    e_addr  = 16'(int'(a) + i5);
    e_wdata = b;
    e_npc   = 16'(int'(m_pc) + 2);
    case (w[15:11])
      5'b00000: e_halt = 1;
      5'b01000: begin e_wr = 1; e_sel = w[7:5]; e_data = 16'(int'(a) + i5); end
      5'b01001: begin e_wr = 1; e_sel = w[7:5]; e_data = 16'(i5 - int'(a)); end
      5'b10000: begin e_en = 1; e_dwr = 1; end
      5'b10001: begin e_en = 1; e_wr = 1; e_sel = w[7:5]; e_data = m_dm[e_addr[15:1]]; end
      5'b11000: begin e_wr = 1; e_sel = w[10:8]; e_data = 16'(i8); end
      5'b11011: begin
        e_wr = 1; e_sel = w[4:2];
        case (w[1:0])
          2'd0:    e_data = 16'(int'(a) + int'(b));
          2'd1:    e_data = 16'(int'(b) - int'(a));
          2'd2:    e_data = a ^ b;
          default: e_data = a & ~b;
        endcase
      end
      5'b01100: if (a == 16'd0) e_npc = 16'(int'(m_pc) + 2 + i8);
      5'b01101: if (a != 16'd0) e_npc = 16'(int'(m_pc) + 2 + i8);
      5'b00100: e_npc = 16'(int'(m_pc) + 2 + d11);
      default: ;
    endcase
    if (e_halt) begin e_wr = 0; e_en = 0; e_dwr = 0; e_npc = m_pc; end
  endtask

  // Compare process: trace outputs against the model every cycle, before the rising edge
  always @(negedge clk) begin
    if (chk_on) begin
      predict();
      cmp("pc",          32'(pc),          32'(m_pc));
      cmp("imem_addr",   32'(imem_addr),   32'(m_pc));
      cmp("instr",       32'(instr),       32'(e_instr));
      cmp("halt",        32'(halt),        32'(e_halt));
      cmp("reg_wrt",     32'(reg_wrt),     32'(e_wr));
      cmp("dmem_en",     32'(dmem_en),     32'(e_en));
      cmp("dmem_wr",     32'(dmem_wr),     32'(e_dwr));
      cmp("cycle_count", cycle_count,      m_cyc);
      if (e_wr) begin
        cmp("write_reg_sel", 32'(write_reg_sel), 32'(e_sel));
        cmp("write_data",    32'(write_data),    32'(e_data));
      end
      if (e_en) begin
        cmp("dmem_addr", 32'(dmem_addr), 32'(e_addr));
        if (e_dwr) cmp("dmem_wdata", 32'(dmem_wdata), 32'(e_wdata));
      end
    end
  end

  // Model state update on each rising edge; async reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 16'd0; m_cyc = 32'd0; m_halted = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
    end else begin
      predict();
      if (e_halt) m_halted = 1;
      else begin
        if (e_wr) m_r[e_sel] = e_data;
        if (e_en && e_dwr) m_dm[e_addr[15:1]] = e_wdata;
        m_pc  = e_npc;
        m_cyc = m_cyc + 32'd1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [4:0] op;
    int k;
    k = int'($urandom_range(0, 10));
    if (k == 10) op = 5'($urandom);
    else op = ops[k];
    if (op == 5'd0 && $urandom_range(0, 15) != 0) op = 5'b00001;
    return {op, 11'($urandom)};
  endfunction

  // Reset the core, load memories (prog into imem, rest NOP or random), release reset
  task automatic start(input bit rnd, input logic [15:0] d_addr, input logic [15:0] d_val);
    chk_on = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      imem[i] = rnd ? rnd_instr() : 16'h0800;
      dmem[i] = rnd ? 16'($urandom) : 16'h0000;
      m_dm[i] = dmem[i];
    end
    foreach (prog[i]) imem[i] = prog[i];
    if (!rnd) begin dmem[d_addr[15:1]] = d_val; m_dm[d_addr[15:1]] = d_val; end
    repeat (3) begin
      @(posedge clk);
      #2 cmp("pc_in_reset", 32'(pc), 32'h0);
    end
    rst = 1'b1;
    chk_on = 1;
    cmp("pc_after_reset", 32'(pc), 32'h0);
    cmp("cyc_after_reset", cycle_count, 32'h0);
  endtask

  initial begin
    // LBI / ADDI
    prog = '{16'hC17F, 16'h415F};
    start(0, 16'h0, 16'h0);
    cmp("lbi_wrt",  32'(reg_wrt), 32'h1);
    cmp("lbi_sel",  32'(write_reg_sel), 32'h1);
    cmp("lbi_data", 32'(write_data), 32'h007F);
    nxt();
    cmp("addi_sel",  32'(write_reg_sel), 32'h2);
    cmp("addi_data", 32'(write_data), 32'h007E);
    cmp("addi_pc",   32'(pc), 32'h0002);
    cmp("addi_cyc",  cycle_count, 32'h1);

    // ST then LD, with R1=0x10 and R3 loaded with 0xBEEF from 0x14, then J -2 self-loop
    prog = '{16'hC110, 16'h8964, 16'h8162, 16'h8982, 16'h27FE};
    start(0, 16'h0014, 16'hBEEF);
    nxt();
    cmp("ld_r3_data", 32'(write_data), 32'hBEEF);
    nxt();
    cmp("st_en",    32'(dmem_en), 32'h1);
    cmp("st_wr",    32'(dmem_wr), 32'h1);
    cmp("st_addr",  32'(dmem_addr), 32'h0012);
    cmp("st_wdata", 32'(dmem_wdata), 32'hBEEF);
    cmp("st_wrt",   32'(reg_wrt), 32'h0);
    nxt();
    cmp("ld_en",   32'(dmem_en), 32'h1);
    cmp("ld_wr",   32'(dmem_wr), 32'h0);
    cmp("ld_data", 32'(write_data), 32'hBEEF);
    cmp("ld_sel",  32'(write_reg_sel), 32'h4);
    nxt();
    cmp("j_pc", 32'(pc), 32'h0008);
    nxt();
    cmp("j_loop_pc", 32'(pc), 32'h0008);

    // BEQZ taken / BNEZ not taken with R3=0
    prog = '{16'h0800, 16'h0800, 16'h0800, 16'h6302};
    start(0, 16'h0, 16'h0);
    repeat (3) nxt();
    cmp("beqz_pc", 32'(pc), 32'h0006);
    nxt();
    cmp("beqz_next", 32'(pc), 32'h000A);
    prog = '{16'h0800, 16'h0800, 16'h0800, 16'h6B02};
    start(0, 16'h0, 16'h0);
    repeat (4) nxt();
    cmp("bnez_next", 32'(pc), 32'h0008);

    // R-type SUB / ANDN, then HALT at 0x000C
    prog = '{16'hC105, 16'hC203, 16'hD955, 16'hD95B, 16'h0800, 16'h0800, 16'h0000};
    start(0, 16'h0, 16'h0);
    repeat (2) nxt();
    cmp("sub_sel",  32'(write_reg_sel), 32'h5);
    cmp("sub_data", 32'(write_data), 32'hFFFE);
    nxt();
    cmp("andn_sel",  32'(write_reg_sel), 32'h6);
    cmp("andn_data", 32'(write_data), 32'h0004);
    repeat (3) nxt();
    cmp("halt_pc",  32'(pc), 32'h000C);
    cmp("halt",     32'(halt), 32'h1);
    cmp("halt_wrt", 32'(reg_wrt), 32'h0);
    cmp("halt_en",  32'(dmem_en), 32'h0);
    cmp("halt_cyc", cycle_count, 32'd6);
    repeat (5) nxt();
    cmp("halted_pc",   32'(pc), 32'h000C);
    cmp("halted_cyc",  cycle_count, 32'd6);
    cmp("halted_halt", 32'(halt), 32'h1);
    chk_on = 0;
    rst = 1'b0;
    #1;
    cmp("rst_restart_pc",  32'(pc), 32'h0);
    cmp("rst_restart_cyc", cycle_count, 32'h0);
    cmp("rst_restart_halt", 32'(halt), 32'h0);

    // Randomized programs checked by the model every cycle
    prog.delete();
    for (int p = 0; p < 5; p++) begin
      start(1, 16'h0, 16'h0);
      repeat (400) nxt();
    end

    chk_on = 0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_hier.md
# proc_hier

Top-level hierarchy of the single-cycle 16-bit teaching processor: fetch, decode, register file, ALU, branch unit and cycle counter in one clock domain, with instruction and data memories held outside the block. Every instruction completes in one clock cycle. The block exports per-instruction trace signals (PC, instruction, register write, memory access, halt) that the simulation harness samples on each rising clock edge for log and trace generation.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- imem_addr  out  16  instruction fetch byte address; equals pc.
- imem_data  in  16  instruction word; combinational read.
- dmem_addr  out  16  data byte address; equals ALU result.
- dmem_wdata  out  16  store data; equals second register read value.
- dmem_rdata  in  16  load data; combinational read.
- dmem_en  out  1  high for LD or ST.
- dmem_wr  out  1  high for ST only; memory writes on rising edge when dmem_en & dmem_wr.
- pc  out  16  address of the executing instruction.
- instr  out  16  executing instruction; equals imem_data.
- reg_wrt  out  1  register file write this cycle.
- write_reg_sel  out  3  destination register.
- write_data  out  16  value written to the register file.
- halt  out  1  HALT is executing, or the core has halted.
- cycle_count  out  32  clock cycles since reset release.

## Operation
- Registers: R0–R7, 16 bits each. R0 is an ordinary register. Two combinational read ports, one write port, written on the rising edge when reg_wrt=1.
- Decode: opcode is instr[15:11]. Rs=[10:8], Rt=[7:5], Rd(R-type)=[4:2]. imm5=[4:0], imm8=[7:0], disp11=[10:0], all sign-extended.
- 00000 HALT: halt=1. Freezes pc, register file, data memory writes and cycle_count. Held until reset.
- 00001 NOP: pc+=2, no writes.
- 01000 ADDI: R[7:5] = Rs + imm5.
- 01001 SUBI: R[7:5] = imm5 − Rs.
- 10000 ST: Mem[Rs+imm5] = R[7:5]. dmem_wdata is R[7:5].
- 10001 LD: R[7:5] = Mem[Rs+imm5]. write_data is dmem_rdata.
- 11000 LBI: Rs = imm8.
- 11011 R-type, by func [1:0]: 00 ADD Rs+Rt; 01 SUB Rt−Rs; 10 XOR; 11 ANDN (Rs & ~Rt). Result goes to Rd.
- 01100 BEQZ: if Rs==0, pc = pc+2+imm8; otherwise pc+2.
- 01101 BNEZ: if Rs!=0, pc = pc+2+imm8; otherwise pc+2.
- 00100 J: pc = pc+2+disp11.
- Any other opcode executes as NOP.
- Arithmetic: all 16-bit two's complement, wrapping. No flags or exceptions. pc wraps 0xFFFE→0x0000.
- Outputs dmem_en, dmem_wr and reg_wrt are 0 for HALT, NOP, branches and J.
- When reg_wrt=0, write_reg_sel and write_data are don't-care.
- dmem_addr is the ALU output for every instruction. It is meaningful only when dmem_en=1.

## Timing
- Single cycle. Fetch, decode, execute, memory access and writeback all complete between consecutive rising edges.
- All trace outputs are combinational from pc, instr and register state. Sample them just before the rising edge.
- Reset (rst low, asynchronous):
  - pc = 0x0000, registers = 0, cycle_count = 0, halted flag cleared.
  - Outputs follow from pc=0 and the memory contents.
  - No register or memory write occurs while rst is low.
- cycle_count increments on every rising edge with rst high and the core not halted.
- HALT:
  - halt is asserted in the same cycle the HALT instruction is at pc.
  - pc and all state are held on the following edges.
- Reset asserted mid-instruction aborts the instruction. No partial write is committed.
- A register read in the cycle after a write sees the new value. No bypass is needed.

## Test plan
- Reset: hold rst=0 across 3 edges, then release. Expect pc=0x0000, cycle_count=0, and all registers read 0 before the first edge.
- LBI/ADDI: imem[0]=0xC17F (LBI R1,0x7F), imem[2]=0x415F (ADDI R2,R1,−1).
  - Cycle 0: reg_wrt=1, write_reg_sel=1, write_data=0x007F.
  - Cycle 1: write_reg_sel=2, write_data=0x007E, pc=0x0002.
- ST then LD, using R1=0x0010 and R3=0xBEEF:
  - ST R3,R1,#2: dmem_en=1, dmem_wr=1, dmem_addr=0x0012, dmem_wdata=0xBEEF, reg_wrt=0.
  - Subsequent LD R4,R1,#2: dmem_en=1, dmem_wr=0, write_data=0xBEEF, write_reg_sel=4.
- Branches, with R3=0:
  - BEQZ R3,#2 at pc 0x0006: next pc=0x000A.
  - BNEZ R3,#2 at the same pc: next pc=0x0008.
  - J with disp11=−2: pc unchanged, giving a self-loop.
- R-type, with R1=5 and R2=3:
  - SUB Rs=R1, Rt=R2, Rd=R5: write_data=0xFFFE.
  - ANDN: write_data=0x0004.
- HALT: instr 0x0000 at pc 0x000C. Expect halt=1 with reg_wrt=dmem_en=0. pc and cycle_count stay constant over 5 further edges. Asserting rst restarts execution from pc 0x0000.
